// File: rtl/flux_diag_pkg.sv
// Shared definitions for the flux diagnostics blocks: FSM encoding, data-rate codes
// and the peak-center thresholds (in clocks) that separate them.
package flux_diag_pkg;

  typedef enum logic [2:0] {StIdle, StClear, StAcquire, StScan, StDone} flux_state_e;

  localparam logic [1:0] Rate500k = 2'b00;
  localparam logic [1:0] Rate300k = 2'b01;
  localparam logic [1:0] Rate250k = 2'b10;
  localparam logic [1:0] Rate1m   = 2'b11;

  localparam int unsigned Thr1m   = 150;
  localparam int unsigned Thr500k = 265;
  localparam int unsigned Thr300k = 365;

  function automatic logic [1:0] rate_code(input int unsigned center);
    if (center < Thr1m) return Rate1m;
    if (center < Thr500k) return Rate500k;
    if (center < Thr300k) return Rate300k;
    return Rate250k;
  endfunction

endpackage

// File: rtl/flux_hist_ram.sv
// Single-port histogram bin store with a registered (1-cycle) read.
module flux_hist_ram #(
  parameter int unsigned NUM_BINS = 64,
  parameter int unsigned BIN_W    = 16,
  localparam int unsigned AW      = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [BIN_W-1:0] wdata,
  output logic [BIN_W-1:0] rdata
);

  logic [BIN_W-1:0] mem [NUM_BINS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/flux_histogram.sv
// Flux-transition interval histogram with optional peak search / data-rate detection.
// Peak search is built only when FLUX_HIST_PEAK_EN is defined.
module flux_histogram
  import flux_diag_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned NUM_BINS      = 64,
  parameter int unsigned BIN_SHIFT     = 3,
  parameter int unsigned BIN_W         = 16,
  parameter int unsigned MIN_INTERVAL  = 40,
  parameter int unsigned SAMPLE_TARGET = 1024,
  localparam int unsigned AW           = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flux_transition,
  input  logic             start,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [BIN_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sample_count,
  output logic [15:0]      overflow_count,
  output logic [15:0]      reject_count,
  output logic [AW-1:0]    peak_bin,
  output logic [BIN_W-1:0] peak_count,
  output logic [1:0]       detected_rate,
  output logic             rate_valid
);

`ifdef FLUX_HIST_PEAK_EN
  localparam flux_state_e AcqNext = StScan;
`else
  localparam flux_state_e AcqNext = StDone;
`endif

  localparam logic [CNT_W:0] MinIv     = (CNT_W+1)'(MIN_INTERVAL);
  localparam logic [CNT_W:0] NumBinsW  = (CNT_W+1)'(NUM_BINS);
  localparam logic [15:0]    SampleTgt = 16'(SAMPLE_TARGET);

  flux_state_e      state_q;
  logic [AW-1:0]    clr_idx_q, rmw_addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             seen_edge_q, rmw_q, done_q, rd_valid_q;
  logic [15:0]      sample_q, overflow_q, reject_q;

  logic             idle_or_done, edge_seen, edge_ok, is_reject, is_over, accept, acq_exit;
  logic [CNT_W:0]   interval, bin_full;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [BIN_W-1:0] ram_wdata, ram_rdata, inc_sat;

  // The counter restarts at 0 on the clock after an edge, so +1 gives the edge spacing.
  assign interval     = {1'b0, cnt_q} + 1'b1;
  assign bin_full     = interval >> BIN_SHIFT;
  assign is_reject    = interval < MinIv;
  assign is_over      = bin_full >= NumBinsW;
  assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
  assign edge_seen    = (state_q == StAcquire) && flux_transition && enable;
  assign edge_ok      = edge_seen && seen_edge_q && (sample_q < SampleTgt);
  assign accept       = edge_ok && !is_reject && !is_over;
  assign acq_exit     = (state_q == StAcquire) && !rmw_q && (!enable || sample_q >= SampleTgt);
  assign inc_sat      = (ram_rdata == '1) ? ram_rdata : ram_rdata + 1'b1;

`ifdef FLUX_HIST_PEAK_EN
  logic [AW:0] scan_idx_q;
`endif

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = '0;
    case (state_q)
      StClear: begin
        ram_we   = 1'b1;
        ram_addr = clr_idx_q;
      end
      StAcquire: begin
        if (rmw_q) begin
          ram_we    = 1'b1;
          ram_addr  = rmw_addr_q;
          ram_wdata = inc_sat;
        end else begin
          ram_addr = bin_full[AW-1:0];
        end
      end
`ifdef FLUX_HIST_PEAK_EN
      StScan:  ram_addr = scan_idx_q[AW-1:0];
`endif
      default: ram_addr = rd_addr;
    endcase
  end

  flux_hist_ram #(
    .NUM_BINS (NUM_BINS),
    .BIN_W    (BIN_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      clr_idx_q   <= '0;
      rmw_addr_q  <= '0;
      cnt_q       <= '0;
      seen_edge_q <= 1'b0;
      rmw_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      sample_q    <= '0;
      overflow_q  <= '0;
      reject_q    <= '0;
`ifdef FLUX_HIST_PEAK_EN
      scan_idx_q  <= '0;
`endif
    end else begin
      rd_valid_q <= rd_en && idle_or_done;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StClear;
            clr_idx_q   <= '0;
            done_q      <= 1'b0;
            sample_q    <= '0;
            overflow_q  <= '0;
            reject_q    <= '0;
            seen_edge_q <= 1'b0;
            rmw_q       <= 1'b0;
          end
        end
        StClear: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == AW'(NUM_BINS - 1)) state_q <= StAcquire;
        end
        StAcquire: begin
          rmw_q <= accept;
          if (accept) begin
            rmw_addr_q <= bin_full[AW-1:0];
            sample_q   <= sample_q + 1'b1;
          end
          if (edge_seen) begin
            cnt_q       <= '0;
            seen_edge_q <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (edge_ok && is_reject && reject_q != '1) reject_q <= reject_q + 1'b1;
          if (edge_ok && !is_reject && is_over && overflow_q != '1) begin
            overflow_q <= overflow_q + 1'b1;
          end
          if (acq_exit) begin
            state_q <= AcqNext;
            done_q  <= (AcqNext == StDone);
`ifdef FLUX_HIST_PEAK_EN
            scan_idx_q <= '0;
`endif
          end
        end
`ifdef FLUX_HIST_PEAK_EN
        StScan: begin
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_idx_q == (AW+1)'(NUM_BINS)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q == StClear) || (state_q == StAcquire) || (state_q == StScan);
  assign done           = done_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_valid_q ? ram_rdata : '0;
  assign sample_count   = sample_q;
  assign overflow_count = overflow_q;
  assign reject_count   = reject_q;

`ifdef FLUX_HIST_PEAK_EN
  logic [AW-1:0]    peak_bin_q, cand_bin;
  logic [BIN_W-1:0] peak_count_q, cand_cnt;
  logic [1:0]       rate_q;
  logic             rate_valid_q, scan_hit;
  int unsigned      center;

  // RAM data lags the scan address by one cycle; strict '>' keeps the lowest index on ties.
  always_comb begin
    scan_hit = (scan_idx_q != '0) && (ram_rdata > peak_count_q);
    cand_bin = scan_hit ? AW'(scan_idx_q - 1'b1) : peak_bin_q;
    cand_cnt = scan_hit ? ram_rdata : peak_count_q;
    center   = (32'(cand_bin) << BIN_SHIFT) + (32'd1 << (BIN_SHIFT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else if (start && idle_or_done) begin
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else if (state_q == StScan) begin
      peak_bin_q   <= cand_bin;
      peak_count_q <= cand_cnt;
      if (scan_idx_q == (AW+1)'(NUM_BINS)) begin
        rate_q       <= rate_code(center);
        rate_valid_q <= (cand_cnt != '0);
      end
    end
  end

  assign peak_bin      = peak_bin_q;
  assign peak_count    = peak_count_q;
  assign detected_rate = rate_q;
  assign rate_valid    = rate_valid_q;
`else
  assign peak_bin      = '0;
  assign peak_count    = '0;
  assign detected_rate = '0;
  assign rate_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_flux_histogram.sv
// Directed bench for flux_histogram: a default-width instance and a BIN_W=4 instance
// share stimulus; SAMPLE_TARGET is reduced to 128 to keep run length short.
module tb_flux_histogram;

`ifdef FLUX_HIST_PEAK_EN
  localparam bit PeakEn = 1'b1;
`else
  localparam bit PeakEn = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, flux = 1'b0, start = 1'b0, rd_en = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data, sample_count, overflow_count, reject_count, peak_count;
  logic [3:0]  rd_data4, peak_count4;
  logic [15:0] sample_count4, overflow_count4, reject_count4;
  logic [5:0]  peak_bin, peak_bin4;
  logic [1:0]  detected_rate, detected_rate4;
  logic        rd_valid, busy, done, rate_valid;
  logic        rd_valid4, busy4, done4, rate_valid4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flux_histogram #(.SAMPLE_TARGET(128)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .flux_transition(flux), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .sample_count(sample_count), .overflow_count(overflow_count),
    .reject_count(reject_count), .peak_bin(peak_bin), .peak_count(peak_count),
    .detected_rate(detected_rate), .rate_valid(rate_valid)
  );

  flux_histogram #(.SAMPLE_TARGET(128), .BIN_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .flux_transition(flux), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data4), .rd_valid(rd_valid4),
    .busy(busy4), .done(done4), .sample_count(sample_count4),
    .overflow_count(overflow_count4), .reject_count(reject_count4), .peak_bin(peak_bin4),
    .peak_count(peak_count4), .detected_rate(detected_rate4), .rate_valid(rate_valid4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n edges, each followed by spacing-1 idle clocks, so consecutive edges are spacing apart.
  task automatic edges(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      flux = 1'b1;
      @(posedge clk);
      #1 flux = 1'b0;
      repeat (spacing - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 2000);
  endtask

  task automatic rd(input int a, output logic [15:0] d, output logic [3:0] d4, output logic v);
    rd_addr = 6'(a);
    rd_en   = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    d  = rd_data;
    d4 = rd_data4;
    v  = rd_valid;
  endtask

  task automatic count_nonzero(output int nz);
    logic [15:0] d;
    logic [3:0]  d4;
    logic        v;
    nz = 0;
    for (int a = 0; a < 64; a++) begin
      rd(a, d, d4, v);
      if (d != 0 || d4 != 0 || !v) nz++;
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  d4;
    logic        v;
    int          lat, nz;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_samples", sample_count, 0);
    check("rst_peak_bin", peak_bin, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 200-clock spacing: all samples land in bin 25; an edge during CLEAR must be ignored
    enable = 1'b1;
    pulse_start();
    check("clear_busy_first", busy, 1);
    repeat (10) @(posedge clk);
    #1 flux = 1'b1;
    @(posedge clk);
    #1 flux = 1'b0;
    repeat (52) @(posedge clk);
    #1;
    check("clear_busy_last", busy, 1);
    repeat (5) @(posedge clk);
    #1;
    edges(129, 200);
    wait_done(lat);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_samples", sample_count, 128);
    check("t1_reject", reject_count, 0);
    check("t1_overflow", overflow_count, 0);
    check("t1_peak_bin", peak_bin, PeakEn ? 25 : 0);
    check("t1_peak_count", peak_count, PeakEn ? 128 : 0);
    check("t1_rate", detected_rate, 0);
    check("t1_rate_valid", rate_valid, PeakEn ? 1 : 0);
    rd(25, d, d4, v);
    check("t1_bin25", d, 128);
    check("t1_bin25_w4", d4, 15);
    check("t1_rd_valid", v, 1);
    rd(24, d, d4, v);
    check("t1_bin24", d, 0);

    // Overflow at 600-clock spacing, rejects at 20-clock spacing
    pulse_start();
    check("t2_done_cleared", done, 0);
    check("t2_samples_cleared", sample_count, 0);
    repeat (70) @(posedge clk);
    #1;
    edges(4, 600);
    check("t2_overflow3", overflow_count, 3);
    edges(5, 20);
    check("t2_overflow4", overflow_count, 4);
    check("t2_reject", reject_count, 4);
    enable = 1'b0;
    wait_done(lat);
    check("t2_done", done, 1);
    check("t2_samples", sample_count, 0);
    check("t2_rate_valid", rate_valid, 0);
    count_nonzero(nz);
    check("t2_all_bins_zero", nz, 0);

    // 100-clock spacing, enable dropped after 50 samples; readout ignored in ACQUIRE
    enable = 1'b1;
    pulse_start();
    repeat (70) @(posedge clk);
    #1;
    edges(51, 100);
    rd(25, d, d4, v);
    check("t3_rd_valid_acq", v, 0);
    check("t3_busy", busy, 1);
    enable = 1'b0;
    wait_done(lat);
    check("t3_done_latency", lat, PeakEn ? 66 : 1);
    check("t3_done", done, 1);
    check("t3_samples", sample_count, 50);
    check("t3_peak_bin", peak_bin, PeakEn ? 12 : 0);
    check("t3_rate", detected_rate, PeakEn ? 3 : 0);
    rd(12, d, d4, v);
    check("t3_bin12", d, 50);
    check("t3_bin12_w4", d4, 15);

    // Reset mid-ACQUIRE, then a fresh CLEAR must zero every bin
    enable = 1'b1;
    pulse_start();
    repeat (70) @(posedge clk);
    #1;
    edges(10, 200);
    check("t4_samples_pre", sample_count, 9);
    reset = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_samples", sample_count, 0);
    check("t4_rd_valid", rd_valid, 0);
    check("t4_peak_count", peak_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    enable = 1'b0;
    pulse_start();
    wait_done(lat);
    check("t4_done_after", done, 1);
    count_nonzero(nz);
    check("t4_all_bins_zero", nz, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
